// File: rtl/usb_fifo_arbiter.sv
// Bus arbiter for the shared synchronous FIFO interface to the USB bridge.
// Time-shares one bidirectional bus between receive and transmit bursts.
module usb_fifo_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             usb_rx_empty,
   input  logic             usb_tx_full,
   input  logic [WIDTH-1:0] usb_data_in,
   input  logic [3:0]       usb_be_in,
   output logic [WIDTH-1:0] usb_data_out,
   output logic [3:0]       usb_be_out,
   output logic             usb_data_oe,
   output logic             usb_outen_l,
   output logic             usb_rden_l,
   output logic             usb_wren_l,
   output logic [WIDTH-1:0] rx_data,
   output logic [3:0]       rx_be,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE,
      RX_OE,
      RX_READ,
      TX_WRITE,
      TURN
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_inc;
   logic             last_tx_q;
   logic [WIDTH-1:0] rx_data_q;
   logic [3:0]       rx_be_q;
   logic             rx_valid_q;

   logic rx_pend;
   logic tx_pend;
   logic room;
   logic rd_go;
   logic wr_go;

   assign rx_pend = !usb_rx_empty && rx_ready;
   assign tx_pend = tx_valid && !usb_tx_full;
   assign room    = cnt_q < MAXC;
   assign cnt_inc = cnt_q + CW'(1);

   // Strobes are combinational so a stall stops the transfer in its own cycle.
   assign rd_go = (state_q == RX_READ) && rx_pend && room;
   assign wr_go = (state_q == TX_WRITE) && tx_pend && room;

   assign usb_outen_l  = !((state_q == RX_OE) || (state_q == RX_READ));
   assign usb_rden_l   = !rd_go;
   assign usb_wren_l   = !wr_go;
   assign tx_ready     = wr_go;
   assign usb_data_oe  = (state_q == TX_WRITE);
   assign usb_data_out = usb_data_oe ? tx_data : '0;
   assign usb_be_out   = usb_data_oe ? 4'hF : 4'h0;

   assign rx_data  = rx_data_q;
   assign rx_be    = rx_be_q;
   assign rx_valid = rx_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_tx_q  <= 1'b1;
         rx_data_q  <= '0;
         rx_be_q    <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // On a tie the direction not served last wins.
               if (rx_pend && (!tx_pend || last_tx_q)) begin
                  state_q   <= RX_OE;
                  last_tx_q <= 1'b0;
               end else if (tx_pend) begin
                  state_q   <= TX_WRITE;
                  last_tx_q <= 1'b1;
               end
            end
            RX_OE: begin
               state_q <= RX_READ;
            end
            RX_READ: begin
               if (rd_go) begin
                  rx_data_q  <= usb_data_in;
                  rx_be_q    <= usb_be_in;
                  rx_valid_q <= 1'b1;
                  cnt_q      <= cnt_inc;
                  if (cnt_inc == MAXC) state_q <= TURN;
               end else begin
                  state_q <= TURN;
               end
            end
            TX_WRITE: begin
               if (wr_go) begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == MAXC) state_q <= TURN;
               end else begin
                  state_q <= TURN;
               end
            end
            TURN: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Directed bench for usb_fifo_arbiter with a simple bridge FIFO model.
// Both bus directions are modelled as indexed word streams.
module tb_usb_fifo_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        usb_tx_full = 1'b0;
   logic        rx_ready = 1'b1;
   logic        tx_en = 1'b0;
   int          rx_idx = 0;
   int          rx_lim = 0;
   int          tx_idx = 0;
   int          tx_lim = 0;

   logic        usb_rx_empty;
   logic [31:0] usb_data_in;
   logic [3:0]  usb_be_in;
   logic [31:0] usb_data_out;
   logic [3:0]  usb_be_out;
   logic        usb_data_oe;
   logic        usb_outen_l;
   logic        usb_rden_l;
   logic        usb_wren_l;
   logic [31:0] rx_data;
   logic [3:0]  rx_be;
   logic        rx_valid;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   function automatic logic [31:0] rxw(input int i);
      return {8'hA5, 8'(i), 8'(i * 3), 8'(~i)};
   endfunction

   function automatic logic [3:0] rxb(input int i);
      return 4'(i * 7 + 1);
   endfunction

   function automatic logic [31:0] txw(input int i);
      return {8'h3C, 8'(i * 5), 16'(i)};
   endfunction

   assign usb_rx_empty = (rx_idx >= rx_lim);
   assign usb_data_in  = rxw(rx_idx);
   assign usb_be_in    = rxb(rx_idx);
   assign tx_valid     = tx_en && (tx_idx < tx_lim);
   assign tx_data      = txw(tx_idx);

   usb_fifo_arbiter #(.WIDTH(32), .MAX_BURST(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .usb_rx_empty (usb_rx_empty),
      .usb_tx_full  (usb_tx_full),
      .usb_data_in  (usb_data_in),
      .usb_be_in    (usb_be_in),
      .usb_data_out (usb_data_out),
      .usb_be_out   (usb_be_out),
      .usb_data_oe  (usb_data_oe),
      .usb_outen_l  (usb_outen_l),
      .usb_rden_l   (usb_rden_l),
      .usb_wren_l   (usb_wren_l),
      .rx_data      (rx_data),
      .rx_be        (rx_be),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   int   checks = 0;
   int   failures = 0;
   int   rx_got = 0;
   int   cyc_n = 0;
   logic mon_en = 1'b1;
   logic rec_en = 1'b0;
   logic prev_rxbus = 1'b0;
   logic prev_oe = 1'b0;
   logic [4:0] lg [64];
   int   g_dir [16];
   int   g_len [16];
   int   g_n = 0;
   int   cur_dir = 0;
   int   cur_len = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_run();
      if (cur_len > 0 && g_n < 16) begin
         g_dir[g_n] = cur_dir;
         g_len[g_n] = cur_len;
         g_n++;
      end
      cur_len = 0;
   endtask

   // One clock: observe at negedge, advance the bridge model after posedge.
   task automatic cyc();
      logic rd;
      logic wr;
      int   d;
      @(negedge clk);
      rd = !usb_rden_l;
      wr = tx_ready && tx_valid;
      if (cyc_n < 64)
         lg[cyc_n] = {usb_outen_l, usb_rden_l, usb_wren_l, usb_data_oe, rx_valid};
      chk("bus_excl", 64'(usb_data_oe && !usb_outen_l), 64'(0));
      chk("turnaround", 64'((prev_rxbus && usb_data_oe) ||
                            (prev_oe && !usb_outen_l)), 64'(0));
      if (!usb_data_oe)
         chk("bus_idle_val", 64'({usb_be_out, usb_data_out}), 64'(0));
      if (wr) begin
         chk("tx_word", 64'(usb_data_out), 64'(txw(tx_idx)));
         chk("tx_be", 64'(usb_be_out), 64'(4'hF));
      end
      if (rx_valid && mon_en) begin
         chk("rx_word", 64'(rx_data), 64'(rxw(rx_got)));
         chk("rx_be", 64'(rx_be), 64'(rxb(rx_got)));
         rx_got++;
      end
      if (rec_en) begin
         d = rd ? 1 : (wr ? 2 : 0);
         if (d != 0) begin
            if (d == cur_dir && cur_len > 0) cur_len++;
            else begin
               push_run();
               cur_dir = d;
               cur_len = 1;
            end
         end else begin
            push_run();
         end
      end
      prev_rxbus = !usb_outen_l;
      prev_oe = usb_data_oe;
      @(posedge clk);
      #1;
      if (rd) rx_idx++;
      if (wr) tx_idx++;
      cyc_n++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int ed [5] = '{1, 2, 1, 2, 1};
   int el [5] = '{16, 16, 16, 16, 8};
   int base;
   int tb0;
   logic [2:0] e;

   initial begin
      // Reset held for five cycles
      repeat (5) cyc();
      chk("rst_outs", 64'({usb_outen_l, usb_rden_l, usb_wren_l,
                           usb_data_oe, rx_valid, tx_ready}), 64'(6'b111000));
      chk("rst_rxdata", 64'({rx_be, rx_data}), 64'(0));
      rst = 1'b0;
      cyc_n = 0;
      repeat (4) cyc();
      for (int k = 0; k < 4; k++)
         chk("idle_hold", 64'(lg[k]), 64'(5'b11100));

      // Contention: RX wins the first tie, then strict alternation
      g_n = 0;
      rec_en = 1'b1;
      rx_lim = rx_idx + 40;
      tx_lim = tx_idx + 200;
      tx_en = 1'b1;
      for (int i = 0; i < 200 && !(rx_idx == rx_lim && g_n >= 5); i++) cyc();
      repeat (10) cyc();
      tx_en = 1'b0;
      repeat (6) cyc();
      rec_en = 1'b0;
      chk("cont_grants", 64'(g_n), 64'(6));
      for (int i = 0; i < 5; i++) begin
         chk("cont_dir", 64'(g_dir[i]), 64'(ed[i]));
         chk("cont_len", 64'(g_len[i]), 64'(el[i]));
      end
      chk("cont_dir_last", 64'(g_dir[5]), 64'(2));
      chk("cont_rx_total", 64'(rx_got), 64'(40));

      // Eight-word RX burst, cycle-exact strobe timing
      rx_lim = rx_idx + 8;
      cyc_n = 0;
      repeat (14) cyc();
      for (int k = 0; k < 14; k++) begin
         e = {!(k >= 1 && k <= 10), !(k >= 2 && k <= 9), (k >= 3 && k <= 10)};
         chk("rx_burst_cyc", 64'({lg[k][4:3], lg[k][0]}), 64'(e));
      end
      chk("rx_burst_total", 64'(rx_got), 64'(48));

      // RX backpressure after the fifth word
      base = rx_idx;
      rx_lim = base + 10;
      for (int i = 0; i < 20 && rx_idx != base + 5; i++) cyc();
      chk("bp_reach5", 64'(rx_idx), 64'(base + 5));
      rx_ready = 1'b0;
      #1;
      chk("bp_rden_same_cyc", 64'({usb_rden_l, usb_outen_l}), 64'(2'b10));
      repeat (6) cyc();
      chk("bp_delivered", 64'(rx_got), 64'(base + 5));
      chk("bp_read", 64'(rx_idx), 64'(base + 5));
      rx_ready = 1'b1;
      for (int i = 0; i < 30 && rx_got != base + 10; i++) cyc();
      chk("bp_resume", 64'(rx_got), 64'(base + 10));
      repeat (4) cyc();

      // Reset asserted in the middle of an RX burst
      base = rx_idx;
      rx_lim = base + 6;
      for (int i = 0; i < 20 && rx_idx != base + 3; i++) cyc();
      chk("mid_pre", 64'({usb_rden_l, rx_valid}), 64'(2'b01));
      rst = 1'b1;
      #1;
      chk("mid_async", 64'({usb_rden_l, usb_outen_l, rx_valid}), 64'(3'b110));
      mon_en = 1'b0;
      rx_lim = rx_idx;
      repeat (2) cyc();
      rst = 1'b0;

      // TX from IDLE after reset, then bridge full after the third word
      tb0 = tx_idx;
      tx_lim = tb0 + 5;
      tx_en = 1'b1;
      cyc_n = 0;
      cyc();
      cyc();
      chk("tx_lat_c0", 64'(lg[0][2:1]), 64'(2'b10));
      chk("tx_lat_c1", 64'(lg[1][2:1]), 64'(2'b01));
      for (int i = 0; i < 10 && tx_idx != tb0 + 3; i++) cyc();
      chk("tx_reach3", 64'(tx_idx), 64'(tb0 + 3));
      usb_tx_full = 1'b1;
      #1;
      chk("tx_full_same_cyc", 64'({usb_wren_l, tx_ready}), 64'(2'b10));
      chk("tx_word4_held", 64'(usb_data_out), 64'(txw(tb0 + 3)));
      repeat (5) cyc();
      chk("tx_full_stall", 64'(tx_idx), 64'(tb0 + 3));
      usb_tx_full = 1'b0;
      for (int i = 0; i < 20 && tx_idx != tb0 + 5; i++) cyc();
      chk("tx_resume", 64'(tx_idx), 64'(tb0 + 5));
      tx_en = 1'b0;
      repeat (4) cyc();
      chk("final_idle", 64'({usb_outen_l, usb_rden_l, usb_wren_l,
                             usb_data_oe, tx_ready}), 64'(5'b11100));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
